// File: rtl/apb_periph_node.sv
`default_nettype none
// ============================================================================
// Module      : apb_periph_node
// Description : APB address-decoding bridge. Accepts one transfer at a time
//               from an upstream APB master, routes it to the lowest-indexed
//               downstream peripheral whose [start, end] region contains the
//               address, and returns the response one cycle after the
//               peripheral completes. A decode miss answers with an error
//               immediately; a peripheral that stalls too long is aborted
//               with an error.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               start_addr_i, end_addr_i - per-peripheral inclusive regions
//               paddr_i .. penable_i     - upstream APB request
//               prdata_o .. pslverr_o    - upstream APB response
//               paddr_o .. penable_o     - downstream APB request (psel one-hot)
//               prdata_i .. pslverr_i    - downstream APB responses
//               timeout_o, decerr_o      - one-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module apb_periph_node #(
    parameter int NB_MASTER      = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
    input  logic [APB_ADDR_WIDTH-1:0]                     paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                     pwdata_i,
    input  logic                                          pwrite_i,
    input  logic                                          psel_i,
    input  logic                                          penable_i,
    output logic [APB_DATA_WIDTH-1:0]                     prdata_o,
    output logic                                          pready_o,
    output logic                                          pslverr_o,
    output logic [APB_ADDR_WIDTH-1:0]                     paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                     pwdata_o,
    output logic                                          pwrite_o,
    output logic [NB_MASTER-1:0]                          psel_o,
    output logic                                          penable_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
    input  logic [NB_MASTER-1:0]                          pready_i,
    input  logic [NB_MASTER-1:0]                          pslverr_i,
    output logic                                          timeout_o,
    output logic                                          decerr_o
);

    // A zero timeout still needs a 1-bit counter to keep widths legal.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [NB_MASTER-1:0]      r_sel;      // one-hot latched target
    logic [c_CNT_W-1:0]        r_cnt;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic [NB_MASTER-1:0]      r_psel;
    logic                      r_penable;
    logic [APB_DATA_WIDTH-1:0] r_prdata;
    logic                      r_pready;
    logic                      r_pslverr;
    logic                      r_timeout;
    logic                      r_decerr;

    logic [NB_MASTER-1:0]      w_hit;
    logic [NB_MASTER-1:0]      w_first;
    logic                      w_rdy;
    logic                      w_err;
    logic [APB_DATA_WIDTH-1:0] w_rdata;
    logic [c_CNT_W-1:0]        w_cnt_next;

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NB_MASTER; k++) begin
            w_hit[k] = (paddr_i >= start_addr_i[k]) && (paddr_i <= end_addr_i[k]);
        end
    end

    // Isolate the lowest set bit: lowest-index region wins on overlap.
    assign w_first = w_hit & (~w_hit + NB_MASTER'(1));

    // Only the latched target's response lines are looked at.
    always_comb begin
        w_rdy   = 1'b0;
        w_err   = 1'b0;
        w_rdata = '0;
        for (int k = 0; k < NB_MASTER; k++) begin
            if (r_sel[k]) begin
                w_rdy   = w_rdy   | pready_i[k];
                w_err   = w_err   | pslverr_i[k];
                w_rdata = w_rdata | prdata_i[k];
            end
        end
    end

    assign w_cnt_next = r_cnt + c_CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_timeout <= 1'b0;
            r_decerr  <= 1'b0;
        end else begin
            // Response and status flags are single-cycle by default.
            r_pready  <= 1'b0;
            r_timeout <= 1'b0;
            r_decerr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (psel_i && !penable_i) begin
                        r_paddr  <= paddr_i;
                        r_pwdata <= pwdata_i;
                        r_pwrite <= pwrite_i;
                        r_sel    <= w_first;
                        if (|w_hit) begin
                            r_psel  <= w_first;
                            r_state <= S_SETUP;
                        end else begin
                            r_prdata  <= '0;
                            r_pslverr <= 1'b1;
                            r_pready  <= 1'b1;
                            r_decerr  <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // Slave completion has priority over a simultaneous timeout.
                    if (w_rdy) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_prdata  <= w_rdata;
                        r_pslverr <= w_err;
                        r_pready  <= 1'b1;
                        r_state   <= S_RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (w_cnt_next == c_TMO)) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_prdata  <= '0;
                        r_pslverr <= 1'b1;
                        r_pready  <= 1'b1;
                        r_timeout <= 1'b1;
                        r_cnt     <= w_cnt_next;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign paddr_o   = r_paddr;
    assign pwdata_o  = r_pwdata;
    assign pwrite_o  = r_pwrite;
    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign prdata_o  = r_prdata;
    assign pready_o  = r_pready;
    assign pslverr_o = r_pslverr;
    assign timeout_o = r_timeout;
    assign decerr_o  = r_decerr;

endmodule
`default_nettype wire

// File: tb/tb_apb_periph_node.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_periph_node
// Description : Self-checking bench for apb_periph_node. Each transfer's
//               expected cycle-by-cycle handshake and response are computed
//               from the region map and the slave's wait count.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_periph_node;

    localparam int NB  = 10;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NB-1:0][AW-1:0] start_addr;
    logic [NB-1:0][AW-1:0] end_addr;
    logic [AW-1:0]         paddr;
    logic [DW-1:0]         pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DW-1:0]         prdata_up;
    logic                  pready_up;
    logic                  pslverr_up;
    logic [AW-1:0]         paddr_dn;
    logic [DW-1:0]         pwdata_dn;
    logic                  pwrite_dn;
    logic [NB-1:0]         psel_dn;
    logic                  penable_dn;
    logic [NB-1:0][DW-1:0] prdata_dn;
    logic [NB-1:0]         pready_dn;
    logic [NB-1:0]         pslverr_dn;
    logic                  timeout;
    logic                  decerr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_periph_node #(
        .NB_MASTER      (NB),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_addr_i (start_addr),
        .end_addr_i   (end_addr),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pwrite_i     (pwrite),
        .psel_i       (psel),
        .penable_i    (penable),
        .prdata_o     (prdata_up),
        .pready_o     (pready_up),
        .pslverr_o    (pslverr_up),
        .paddr_o      (paddr_dn),
        .pwdata_o     (pwdata_dn),
        .pwrite_o     (pwrite_dn),
        .psel_o       (psel_dn),
        .penable_o    (penable_dn),
        .prdata_i     (prdata_dn),
        .pready_i     (pready_dn),
        .pslverr_i    (pslverr_dn),
        .timeout_o    (timeout),
        .decerr_o     (decerr)
    );

    // Reference decode: first region (lowest index) containing the address.
    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int k = 0; k < NB; k++) begin
            if (a >= start_addr[k] && a <= end_addr[k]) return k;
        end
        return -1;
    endfunction

    // Unselected peripherals chatter randomly; the node must ignore them.
    task automatic drive_noise(input logic [NB-1:0] keep_quiet);
        for (int k = 0; k < NB; k++) begin
            prdata_dn[k] = $urandom;
        end
        pready_dn  = NB'($urandom) & ~keep_quiet;
        pslverr_dn = NB'($urandom);
    endtask

    // One upstream transfer. wt = ACCESS cycles the slave stalls before ready.
    task automatic run_xfer(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic wr, input int wt, input logic [DW-1:0] rd,
                            input logic er, input logic drop);
        int            k;
        bit            hit;
        bit            tmo;
        int            resp;
        logic [NB-1:0] oh;
        logic [NB-1:0] exp_sel;
        logic [NB+3:0] exp_v;
        logic [NB+3:0] got_v;
        logic [DW-1:0] exp_rd;
        logic          exp_er;
        k    = ref_decode(a);
        hit  = (k >= 0);
        oh   = '0;
        if (hit) oh[k] = 1'b1;
        tmo  = hit && (wt >= TMO);
        resp = !hit ? 1 : (tmo ? 2 + TMO : 3 + wt);
        exp_rd = (hit && !tmo) ? rd : '0;
        exp_er = (hit && !tmo) ? er : 1'b1;

        @(negedge clk);
        paddr = a; pwdata = wd; pwrite = wr; psel = 1'b1; penable = 1'b0;
        drive_noise(oh);
        for (int c = 1; c <= resp + 1; c++) begin
            @(negedge clk);
            exp_sel = (c < resp) ? oh : '0;
            exp_v   = {exp_sel, hit && c >= 2 && c < resp, c == resp,
                       tmo && c == resp, !hit && c == resp};
            got_v   = {psel_dn, penable_dn, pready_up, timeout, decerr};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL handshake addr=%h cycle=%0d got {psel,pen,rdy,tmo,dec}=%b expected %b",
                         a, c, got_v, exp_v);
            end
            if (c == 1 && hit) begin
                checks++;
                if ({paddr_dn, pwdata_dn, pwrite_dn} !== {a, wd, wr}) begin
                    errors++;
                    $display("FAIL downstream_req addr=%h got %h/%h/%b expected %h/%h/%b",
                             a, paddr_dn, pwdata_dn, pwrite_dn, a, wd, wr);
                end
            end
            if (c == resp) begin
                checks++;
                if ({prdata_up, pslverr_up} !== {exp_rd, exp_er}) begin
                    errors++;
                    $display("FAIL response addr=%h got prdata=%h pslverr=%b expected prdata=%h pslverr=%b",
                             a, prdata_up, pslverr_up, exp_rd, exp_er);
                end
            end
            // Inputs for the cycle now in progress.
            drive_noise(oh);
            if (hit && c >= 2 && c < resp && (c - 2) == wt) begin
                pready_dn[k]  = 1'b1;
                prdata_dn[k]  = rd;
                pslverr_dn[k] = er;
            end
            if (c > resp || (drop && c >= 2)) begin
                psel = 1'b0; penable = 1'b0;
            end else begin
                psel = 1'b1; penable = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({psel_dn, penable_dn, pready_up, pslverr_up, prdata_up, paddr_dn,
             pwdata_dn, pwrite_dn, timeout, decerr} !== '0) begin
            errors++;
            $display("FAIL reset_state got psel=%b pen=%b rdy=%b err=%b rd=%h addr=%h wd=%h expected all zero",
                     psel_dn, penable_dn, pready_up, pslverr_up, prdata_up, paddr_dn, pwdata_dn);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_basic();
        run_xfer(32'h1A10_1004, 32'hCAFE_F00D, 1'b1, 0, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_read_wait();
        // Ready lands on the cycle the counter would reach the limit.
        run_xfer(32'h1A10_1008, $urandom, 1'b0, 3, 32'h1234_5678, 1'b1, 1'b0);
    endtask

    task automatic test_decode_miss();
        run_xfer(32'h1A20_0000, $urandom, 1'b1, 0, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_xfer(32'h1A10_4010, $urandom, 1'b0, 1000, $urandom, 1'b0, 1'b0);
        run_xfer(32'h1A10_5020, $urandom, 1'b0, 1, 32'hA5A5_0F0F, 1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        run_xfer(32'h1A10_2900, $urandom, 1'b0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0);
    endtask

    task automatic test_psel_drop();
        run_xfer(32'h1A10_0040, $urandom, 1'b1, 2, $urandom, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        pready_dn = '0;
        @(negedge clk);
        paddr = 32'h1A10_4010; pwdata = $urandom; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        checks++;
        if ({psel_dn, penable_dn} !== {NB'(10'b00_0000_1000), 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_access got psel=%b pen=%b expected psel=0000001000 pen=1",
                     psel_dn, penable_dn);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({psel_dn, penable_dn, pready_up, pslverr_up, prdata_up, paddr_dn,
             pwdata_dn, pwrite_dn, timeout, decerr} !== '0) begin
            errors++;
            $display("FAIL async_reset got psel=%b pen=%b rdy=%b addr=%h wd=%h expected all zero",
                     psel_dn, penable_dn, pready_up, paddr_dn, pwdata_dn);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(32'h1A10_5100, $urandom, 1'b1, 0, $urandom, 1'b0, 1'b0);
        run_xfer(32'h1A10_1200, $urandom, 1'b0, 1, $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            int            k;
            if ($urandom_range(0, 3) == 0) begin
                a = 32'h1A20_0000 + $urandom_range(0, 32'hFFFF);
            end else begin
                k = $urandom_range(0, NB - 1);
                a = start_addr[k] + $urandom_range(0, end_addr[k] - start_addr[k]);
            end
            run_xfer(a, $urandom, 1'($urandom), $urandom_range(0, 5), $urandom,
                     1'($urandom), 1'($urandom_range(0, 4) == 0));
        end
    endtask

    initial begin
        for (int k = 0; k < NB; k++) begin
            start_addr[k] = 32'h1A11_0000 + 32'(k - 6) * 32'h1000;
            end_addr[k]   = start_addr[k] + 32'h0FFF;
        end
        start_addr[0] = 32'h1A10_0000; end_addr[0] = 32'h1A10_0FFF;
        start_addr[1] = 32'h1A10_1000; end_addr[1] = 32'h1A10_1FFF;
        start_addr[2] = 32'h1A10_2000; end_addr[2] = 32'h1A10_2FFF;
        start_addr[3] = 32'h1A10_4000; end_addr[3] = 32'h1A10_4FFF;
        start_addr[4] = 32'h1A10_5000; end_addr[4] = 32'h1A10_5FFF;
        start_addr[5] = 32'h1A10_2800; end_addr[5] = 32'h1A10_37FF;
        paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        prdata_dn = '0; pready_dn = '0; pslverr_dn = '0;

        test_reset();
        test_write_basic();
        test_read_wait();
        test_decode_miss();
        test_timeout();
        test_overlap();
        test_psel_drop();
        test_reset_mid();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
